multiport_reg_file: RTL and testbench
=====================================

# multiport_reg_file

Parametrised, unified multi-port general-purpose register file for the dual-issue datapath. A single register array is shared by two write ports and NRD read ports, so both pipes see one architectural state. Both write ports have same-cycle write-to-read forwarding. A per-register busy scoreboard lets issue logic reserve a destination and detect read-after-write hazards. Register 0 is hard-wired to zero.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register address width; NREGS = 2**ADDR_W
- NRD, 4, number of read ports
- BYPASS, 1, 1 = forward same-cycle write data to matching read ports; 0 = reads return array contents only
- ZERO_R0, 1, 1 = register 0 reads as zero, ignores writes, never goes busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rbusy  out  NRD  1 = register addressed by read port i has a reservation that is still outstanding
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- busy_vec  out  NREGS  current scoreboard, one bit per register

## Operation
- State: array regs[NREGS] of DATA_W bits, and busy[NREGS] of 1 bit.
- Reset (reset=1 at a rising edge): all regs ← 0 and all busy ← 0. Reset overrides any write or reserve in the same cycle.
- Write: on a rising edge with weN=1, regs[waddrN] ← wdataN and busy[waddrN] ← 0.
- Write collision: we0=we1=1 with waddr0=waddr1 → port 1 data is stored. Port 0 data is discarded.
- Reserve: on a rising edge with rsv_en=1, busy[rsv_addr] ← 1.
- Reserve vs write, same address, same cycle: the reserve wins and busy ends at 1. The write data is still stored.
- ZERO_R0=1: writes and reserves to address 0 have no effect. Read port i with raddr=0 returns 0 and rbusy=0 regardless of bypass, and busy_vec[0] stays 0.
- Reads are combinational, per port i:
  - Base value is regs[raddr_i].
  - If BYPASS=1 and we0=1 with waddr0=raddr_i, the port returns wdata0.
  - If BYPASS=1 and we1=1 with waddr1=raddr_i, the port returns wdata1. Port 1 overrides port 0, which matches the collision rule.
- rbusy[i] = busy[raddr_i] AND NOT (BYPASS AND a write hit on raddr_i this cycle). A same-cycle reserve does not affect rbusy until the next cycle.
- All NRD read ports are independent. Any number of ports may read the same address.

## Timing
- Read latency: 0 cycles (combinational from raddr, regs and the write ports).
- With BYPASS=0, a write becomes visible on rdata and clears rbusy one cycle after the write edge.
- With BYPASS=1, a write is visible in the same cycle its weN is asserted.
- Reserve latency: rbusy and busy_vec assert in the cycle after the edge that sampled rsv_en.
- Output values after reset, assuming no write is active:
  - rdata = 0 on all ports
  - rbusy = 0
  - busy_vec = 0
- Reset asserted mid-operation, including during an outstanding reservation: everything clears at that edge. Pending reservations are lost and must be reissued.
- No combinational path from rsv_en or rsv_addr to any output.

## Test plan
- Reset then read: assert reset for 2 cycles, then set raddr = {15,7,1,0}. Required: rdata = 0 on every port, rbusy = 0, busy_vec = 0.
- Write and bypass (BYPASS=1): we0=1, waddr0=5, wdata0=16'hA5A5, raddr port 2 = 5. Required: port 2 reads A5A5 in the same cycle and continues to read A5A5 after the edge with we0=0. With BYPASS=0, port 2 reads 0 in the write cycle and A5A5 in the next cycle.
- Collision: we0=we1=1, both addresses 9, wdata0=16'h1111, wdata1=16'h2222. Required: bypass reads 2222 in the write cycle and the array holds 2222 afterwards.
- R0 protection: we1=1, waddr1=0, wdata1=16'hFFFF, and rsv_en=1 with rsv_addr=0. Required: reads of address 0 return 0 and busy_vec[0]=0 in every cycle.
- Scoreboard: reserve r3 at cycle n. Required: rbusy=1 for port reading 3 from n+1. Write r3 at cycle m. Required: rbusy=0 in cycle m with BYPASS=1, busy_vec[3]=0 from m+1. Then reserve and write r3 in the same cycle. Required: busy_vec[3]=1 next cycle and the data is stored.
- Reset mid-reservation: reserve r4, r6, and r12, then apply reset for 1 cycle. Required: busy_vec=0, all regs read 0, and a subsequent reserve of r4 sets busy again.

Source files
------------

// File: rtl/multiport_reg_file_if.sv
// Bus bundle for the multi-port register file: two write ports, NRD read
// ports, a reserve request and the scoreboard view.
interface multiport_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NRD    = 4
);
  localparam int NREGS = 2 ** ADDR_W;

  logic                    we0;
  logic [ADDR_W-1:0]       waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    we1;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic [NRD-1:0]          rbusy;
  logic                    rsv_en;
  logic [ADDR_W-1:0]       rsv_addr;
  logic [NREGS-1:0]        busy_vec;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, rsv_en, rsv_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, rsv_en, rsv_addr,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/multiport_reg_file.sv
// Unified register file shared by both issue pipes: two write ports,
// NRD combinational read ports with optional same-cycle forwarding, and a
// per-register busy scoreboard for destination reservation.
module multiport_reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 4,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  multiport_reg_file_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  // Register 0 is immune to writes and reservations when hard-wired to zero.
  assign wr0_ok = bus.we0    && !(ZERO_R0 && bus.waddr0   == '0);
  assign wr1_ok = bus.we1    && !(ZERO_R0 && bus.waddr1   == '0);
  assign rsv_ok = bus.rsv_en && !(ZERO_R0 && bus.rsv_addr == '0);

  // Next state: port 1 applied after port 0 so it wins a collision; the
  // reserve is applied last so it wins over a write clearing busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[bus.waddr0] = bus.wdata0;
      busy_d[bus.waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[bus.waddr1] = bus.wdata1;
      busy_d[bus.waddr1] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  // State register with synchronous reset overriding writes and reserves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic              hit;

    assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

    // Read mux: array value, then forwarding from port 0, then port 1 on top;
    // a forwarded write also hides the stale busy bit.
    always_comb begin
      val = regs_q[ra];
      hit = 1'b0;
      if (BYPASS && bus.we0 && bus.waddr0 == ra) begin
        val = bus.wdata0;
        hit = 1'b1;
      end
      if (BYPASS && bus.we1 && bus.waddr1 == ra) begin
        val = bus.wdata1;
        hit = 1'b1;
      end
      if (ZERO_R0 && ra == '0) begin
        val = '0;
        hit = 1'b1;
      end
    end

    assign bus.rdata[i*DATA_W +: DATA_W] = val;
    assign bus.rbusy[i]                  = busy_q[ra] && !hit;
  end
endmodule

// File: tb/tb_multiport_reg_file.sv
// Randomized and directed bench for multiport_reg_file, running a forwarding
// and a non-forwarding instance side by side against one behavioural model.
module tb_multiport_reg_file;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int NRD = 4;
  localparam int NR  = 16;

  logic clk = 1'b0;
  logic reset;
  logic we0, we1, rsv_en;
  logic [AW-1:0] waddr0, waddr1, rsv_addr;
  logic [DW-1:0] wdata0, wdata1;
  logic [NRD*AW-1:0] raddr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  always #5 clk = ~clk;

  multiport_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) if_b1 ();
  multiport_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) if_b0 ();

  assign if_b1.we0 = we0;       assign if_b0.we0 = we0;
  assign if_b1.waddr0 = waddr0; assign if_b0.waddr0 = waddr0;
  assign if_b1.wdata0 = wdata0; assign if_b0.wdata0 = wdata0;
  assign if_b1.we1 = we1;       assign if_b0.we1 = we1;
  assign if_b1.waddr1 = waddr1; assign if_b0.waddr1 = waddr1;
  assign if_b1.wdata1 = wdata1; assign if_b0.wdata1 = wdata1;
  assign if_b1.raddr = raddr;   assign if_b0.raddr = raddr;
  assign if_b1.rsv_en = rsv_en; assign if_b0.rsv_en = rsv_en;
  assign if_b1.rsv_addr = rsv_addr; assign if_b0.rsv_addr = rsv_addr;

  multiport_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b1))
    dut_b1 (.clk(clk), .reset(reset), .bus(if_b1));
  multiport_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .BYPASS(1'b0), .ZERO_R0(1'b1))
    dut_b0 (.clk(clk), .reset(reset), .bus(if_b0));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Architectural state update from the stated rules.
  task automatic model_update();
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic exp_read(input bit byp, input logic [AW-1:0] a,
                          output logic [DW-1:0] v, output logic b);
    bit hit = 1'b0;
    v = m_regs[a];
    if (byp && we0 && waddr0 == a) begin v = wdata0; hit = 1'b1; end
    if (byp && we1 && waddr1 == a) begin v = wdata1; hit = 1'b1; end
    b = m_busy[a] && !hit;
    if (a == 0) begin v = '0; b = 1'b0; end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    logic [DW-1:0] ev;
    logic          eb;
    logic [NR-1:0] evec;
    for (int i = 0; i < NRD; i++) begin
      a = raddr[i*AW +: AW];
      exp_read(1'b1, a, ev, eb);
      chk($sformatf("b1_rdata%0d", i), 32'(if_b1.rdata[i*DW +: DW]), 32'(ev));
      chk($sformatf("b1_rbusy%0d", i), 32'(if_b1.rbusy[i]), 32'(eb));
      exp_read(1'b0, a, ev, eb);
      chk($sformatf("b0_rdata%0d", i), 32'(if_b0.rdata[i*DW +: DW]), 32'(ev));
      chk($sformatf("b0_rbusy%0d", i), 32'(if_b0.rbusy[i]), 32'(eb));
    end
    for (int r = 0; r < NR; r++) evec[r] = m_busy[r];
    chk("b1_busy_vec", 32'(if_b1.busy_vec), 32'(evec));
    chk("b0_busy_vec", 32'(if_b0.busy_vec), 32'(evec));
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic tail();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half();
    tail();
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
  endtask

  initial begin
    reset = 1; we0 = 0; we1 = 0; rsv_en = 0;
    waddr0 = 0; waddr1 = 0; rsv_addr = 0; wdata0 = 0; wdata1 = 0;
    raddr = {4'd15, 4'd7, 4'd1, 4'd0};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); model_update(); #1;
    end
    reset = 0;

    // Reset then read.
    half();
    chk("rst_rdata", 32'(if_b1.rdata), 32'h0);
    chk("rst_rbusy", 32'(if_b1.rbusy), 32'h0);
    chk("rst_busy_vec", 32'(if_b1.busy_vec), 32'h0);
    tail();

    // Write with and without forwarding.
    raddr = {4'd15, 4'd5, 4'd1, 4'd0};
    we0 = 1; waddr0 = 5; wdata0 = 16'hA5A5;
    half();
    chk("byp_same_cycle", 32'(if_b1.rdata[2*DW +: DW]), 32'hA5A5);
    chk("nobyp_same_cycle", 32'(if_b0.rdata[2*DW +: DW]), 32'h0);
    tail();
    idle();
    half();
    chk("byp_after", 32'(if_b1.rdata[2*DW +: DW]), 32'hA5A5);
    chk("nobyp_after", 32'(if_b0.rdata[2*DW +: DW]), 32'hA5A5);
    tail();

    // Write collision: port 1 wins.
    raddr = {4'd15, 4'd5, 4'd9, 4'd0};
    we0 = 1; waddr0 = 9; wdata0 = 16'h1111;
    we1 = 1; waddr1 = 9; wdata1 = 16'h2222;
    half();
    chk("coll_bypass", 32'(if_b1.rdata[1*DW +: DW]), 32'h2222);
    tail();
    idle();
    half();
    chk("coll_stored", 32'(if_b0.rdata[1*DW +: DW]), 32'h2222);
    tail();

    // Register 0 protection.
    we1 = 1; waddr1 = 0; wdata1 = 16'hFFFF; rsv_en = 1; rsv_addr = 0;
    for (int k = 0; k < 2; k++) begin
      half();
      chk("r0_read", 32'(if_b1.rdata[0 +: DW]), 32'h0);
      chk("r0_busy", 32'(if_b1.busy_vec[0]), 32'h0);
      tail();
    end
    idle();
    half();
    chk("r0_read_after", 32'(if_b0.rdata[0 +: DW]), 32'h0);
    tail();

    // Scoreboard: reserve, release by write, reserve+write same cycle.
    raddr = {4'd3, 4'd5, 4'd9, 4'd0};
    rsv_en = 1; rsv_addr = 3;
    half();
    chk("rsv_not_yet", 32'(if_b1.rbusy[3]), 32'h0);
    tail();
    idle();
    half();
    chk("rsv_busy_b1", 32'(if_b1.rbusy[3]), 32'h1);
    chk("rsv_busy_b0", 32'(if_b0.rbusy[3]), 32'h1);
    tail();
    we0 = 1; waddr0 = 3; wdata0 = 16'h1234;
    half();
    chk("wr_clear_byp", 32'(if_b1.rbusy[3]), 32'h0);
    chk("wr_clear_nobyp", 32'(if_b0.rbusy[3]), 32'h1);
    tail();
    idle();
    half();
    chk("wr_busy_vec3", 32'(if_b1.busy_vec[3]), 32'h0);
    tail();
    we1 = 1; waddr1 = 3; wdata1 = 16'h5678; rsv_en = 1; rsv_addr = 3;
    cycle();
    idle();
    half();
    chk("rsv_wins_busy", 32'(if_b1.busy_vec[3]), 32'h1);
    chk("rsv_wr_data", 32'(if_b0.rdata[3*DW +: DW]), 32'h5678);
    tail();

    // Reset during outstanding reservations.
    rsv_en = 1;
    rsv_addr = 4;  cycle();
    rsv_addr = 6;  cycle();
    rsv_addr = 12; cycle();
    idle();
    reset = 1;
    cycle();
    reset = 0;
    raddr = {4'd12, 4'd6, 4'd5, 4'd3};
    half();
    chk("rst_mid_busy_vec", 32'(if_b1.busy_vec), 32'h0);
    chk("rst_mid_rdata", 32'(if_b0.rdata), 32'h0);
    tail();
    rsv_en = 1; rsv_addr = 4;
    cycle();
    idle();
    half();
    chk("rsv_after_rst", 32'(if_b1.busy_vec), 32'h0010);
    tail();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      we0      = $urandom_range(0, 1);
      we1      = $urandom_range(0, 1);
      rsv_en   = ($urandom_range(0, 9) < 3);
      waddr0   = AW'($urandom_range(0, NR-1));
      waddr1   = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, NR-1));
      rsv_addr = ($urandom_range(0, 3) == 0) ? waddr1 : AW'($urandom_range(0, NR-1));
      wdata0   = DW'($urandom);
      wdata1   = DW'($urandom);
      raddr    = (NRD*AW)'($urandom);
      if ($urandom_range(0, 1) == 1) raddr[AW-1:0] = waddr0;
      if ($urandom_range(0, 1) == 1) raddr[AW +: AW] = waddr1;
      cycle();
    end
    reset = 0;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
